control_sequencer: RTL and testbench

- Multi-cycle FSM control unit that drives the register-select encoder and the datapath strobes: Gra/Grb/Grc, Rin, Rout, BAout, plus PC/MAR/MDR/Y/Z/CON/memory controls.
- Each instruction is stepped through fetch (T0–T2) and execute (T3–T7) phases, keyed on IR[31:27].
- The decoded-register path consumes IR[26:15] downstream. This block only chooses which field is selected, and when.

---
 rtl/control_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through fetch T0-T2 and execute T3-T7.
// Optional single-step pause between instructions via `CONTROL_SEQUENCER_STEP_EN.
module control_sequencer #(
   parameter int T_STATE_W = 3,
   parameter int ALU_OP_W  = 3
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [31:0]         IR,
   input  logic                con_ff,
   input  logic                stop,
`ifdef CONTROL_SEQUENCER_STEP_EN
   input  logic                step,
`endif
   output logic                Gra,
   output logic                Grb,
   output logic                Grc,
   output logic                Rin,
   output logic                Rout,
   output logic                BAout,
   output logic                PCout,
   output logic                PCin,
   output logic                IncPC,
   output logic                MARin,
   output logic                MDRin,
   output logic                MDRout,
   output logic                Read,
   output logic                Write,
   output logic                IRin,
   output logic                Yin,
   output logic                Zin,
   output logic                Zlowout,
   output logic                Cout,
   output logic                CONin,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                run,
   output logic                illegal
);

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_NOP  = 5'b11001;
   localparam logic [4:0] OP_HALT = 5'b11010;

   localparam logic [T_STATE_W-1:0] T0 = T_STATE_W'(3'd0);
   localparam logic [T_STATE_W-1:0] T1 = T_STATE_W'(3'd1);
   localparam logic [T_STATE_W-1:0] T2 = T_STATE_W'(3'd2);
   localparam logic [T_STATE_W-1:0] T3 = T_STATE_W'(3'd3);
   localparam logic [T_STATE_W-1:0] T4 = T_STATE_W'(3'd4);
   localparam logic [T_STATE_W-1:0] T5 = T_STATE_W'(3'd5);
   localparam logic [T_STATE_W-1:0] T6 = T_STATE_W'(3'd6);
   localparam logic [T_STATE_W-1:0] T7 = T_STATE_W'(3'd7);

   localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3'b000);
   localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3'b001);
   localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(3'b010);
   localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3'b011);

   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_HALT  = 2'd1
`ifdef CONTROL_SEQUENCER_STEP_EN
      , MODE_PAUSE = 2'd2
`endif
   } mode_t;

   mode_t                mode_r;
   logic [T_STATE_W-1:0] step_r;
   logic                 stop_pend_r;
   logic [4:0]           opcode_s;
   logic                 halt_req_s;
   logic                 unused_ir_s;

   function automatic logic [T_STATE_W-1:0] last_step(input logic [4:0] op);
      case (op)
         OP_LD, OP_ST:                        last_step = T7;
         OP_BR:                               last_step = T6;
         OP_LDI, OP_ADD, OP_SUB, OP_AND,
         OP_OR, OP_ADDI, OP_ANDI, OP_ORI:     last_step = T5;
         default:                             last_step = T3;
      endcase
   endfunction

   function automatic logic [ALU_OP_W-1:0] alu_code(input logic [4:0] op);
      case (op)
         OP_SUB:          alu_code = ALU_SUB;
         OP_AND, OP_ANDI: alu_code = ALU_AND;
         OP_OR, OP_ORI:   alu_code = ALU_OR;
         default:         alu_code = ALU_ADD;
      endcase
   endfunction

   assign opcode_s    = IR[31:27];
   assign unused_ir_s = ^IR[26:0];
   // A stop seen at any point of the instruction is remembered until its final step.
   assign halt_req_s  = stop | stop_pend_r | (opcode_s == OP_HALT);
   assign run         = (mode_r != MODE_HALT);

   // Sequencer state: T-step advance, instruction boundary, halt and pause handling
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         step_r      <= T0;
         mode_r      <= MODE_RUN;
         stop_pend_r <= 1'b0;
      end else begin
         case (mode_r)
            MODE_RUN: begin
               if (step_r == last_step(opcode_s)) begin
                  step_r      <= T0;
                  stop_pend_r <= 1'b0;
                  if (halt_req_s) begin
                     mode_r <= MODE_HALT;
                  end else begin
`ifdef CONTROL_SEQUENCER_STEP_EN
                     mode_r <= MODE_PAUSE;
`else
                     mode_r <= MODE_RUN;
`endif
                  end
               end else begin
                  step_r      <= step_r + T_STATE_W'(1'b1);
                  stop_pend_r <= stop_pend_r | stop;
               end
            end
            MODE_HALT: begin
               step_r      <= T0;
               mode_r      <= MODE_HALT;
               stop_pend_r <= 1'b0;
            end
`ifdef CONTROL_SEQUENCER_STEP_EN
            MODE_PAUSE: begin
               step_r      <= T0;
               stop_pend_r <= stop_pend_r | stop;
               if (step) begin
                  mode_r <= MODE_RUN;
               end else begin
                  mode_r <= MODE_PAUSE;
               end
            end
`endif
            default: begin
               step_r      <= T0;
               mode_r      <= MODE_HALT;
               stop_pend_r <= 1'b0;
            end
         endcase
      end
   end

   // Strobe decode from the registered T-step and opcode; silent outside normal running
   always_comb begin
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
      Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
      MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
      Read = 1'b0; Write = 1'b0; IRin = 1'b0;
      Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
      Cout = 1'b0; CONin = 1'b0; illegal = 1'b0;
      alu_op = ALU_ADD;
      if (reset_n && (mode_r == MODE_RUN)) begin
         case (step_r)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            default: begin
               case (opcode_s)
                  OP_LD, OP_ST, OP_LDI: begin
                     case (step_r)
                        T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                        T4: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                        T5: begin
                           Zlowout = 1'b1;
                           if (opcode_s == OP_LDI) begin
                              Gra = 1'b1; Rin = 1'b1;
                           end else begin
                              MARin = 1'b1;
                           end
                        end
                        T6: begin
                           MDRin = 1'b1;
                           if (opcode_s == OP_LD) begin
                              Read = 1'b1;
                           end else begin
                              Gra = 1'b1; Rout = 1'b1;
                           end
                        end
                        T7: begin
                           if (opcode_s == OP_LD) begin
                              MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                           end else begin
                              Write = 1'b1;
                           end
                        end
                        default: begin end
                     endcase
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                     case (step_r)
                        T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        T4: begin
                           Zin    = 1'b1;
                           alu_op = alu_code(opcode_s);
                           if ((opcode_s == OP_ADDI) || (opcode_s == OP_ANDI) || (opcode_s == OP_ORI)) begin
                              Cout = 1'b1;
                           end else begin
                              Grc = 1'b1; Rout = 1'b1;
                           end
                        end
                        T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: begin end
                     endcase
                  end
                  OP_BR: begin
                     case (step_r)
                        T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                        T4: begin PCout = 1'b1; Yin = 1'b1; end
                        T5: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                        T6: begin
                           if (con_ff) begin
                              Zlowout = 1'b1; PCin = 1'b1;
                           end else begin
                              Zlowout = 1'b0; PCin = 1'b0;
                           end
                        end
                        default: begin end
                     endcase
                  end
                  OP_JR: begin
                     Gra = (step_r == T3); Rout = (step_r == T3); PCin = (step_r == T3);
                  end
                  OP_NOP, OP_HALT: begin end
                  default: illegal = (step_r == T3);
               endcase
            end
         endcase
      end else begin
         illegal = 1'b0;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction expected strobe tables compared cycle by cycle.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        reset_n, con_ff, stop;
   logic [31:0] IR;
`ifdef CONTROL_SEQUENCER_STEP_EN
   logic        step;
`endif
   logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
   logic Read, Write, IRin, Yin, Zin, Zlowout, Cout, CONin, run, illegal;
   logic [2:0] alu_op;
   logic [24:0] obs;

   int checks = 0;
   int failures = 0;
   logic [24:0] exp_q[$];

   localparam logic [24:0] GRA = 25'd1 << 0,  GRB = 25'd1 << 1,  GRC = 25'd1 << 2,  RIN = 25'd1 << 3;
   localparam logic [24:0] ROUT = 25'd1 << 4, BAOUT = 25'd1 << 5, PCOUT = 25'd1 << 6, PCIN = 25'd1 << 7;
   localparam logic [24:0] INCPC = 25'd1 << 8, MARIN = 25'd1 << 9, MDRIN = 25'd1 << 10, MDROUT = 25'd1 << 11;
   localparam logic [24:0] READ = 25'd1 << 12, WRITE = 25'd1 << 13, IRIN = 25'd1 << 14, YIN = 25'd1 << 15;
   localparam logic [24:0] ZIN = 25'd1 << 16, ZLOW = 25'd1 << 17, COUT = 25'd1 << 18, CONIN = 25'd1 << 19;
   localparam logic [24:0] ILL = 25'd1 << 20, RUN = 25'd1 << 24;

   always #5 clock = ~clock;

   control_sequencer dut (
      .clock(clock), .reset_n(reset_n), .IR(IR), .con_ff(con_ff), .stop(stop),
`ifdef CONTROL_SEQUENCER_STEP_EN
      .step(step),
`endif
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
      .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
      .Cout(Cout), .CONin(CONin), .alu_op(alu_op), .run(run), .illegal(illegal)
   );

   assign obs = {run, alu_op, illegal, CONin, Cout, Zlowout, Zin, Yin, IRin, Write, Read,
                 MDRout, MDRin, MARin, IncPC, PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

   task automatic chk(input string tag, input logic [24:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [24:0] alu_f(input logic [4:0] op);
      logic [24:0] code;
      case (op)
         5'b00100:           code = 25'd1;
         5'b01001, 5'b01100: code = 25'd2;
         5'b01010, 5'b01101: code = 25'd3;
         default:            code = 25'd0;
      endcase
      return code << 21;
   endfunction

   task automatic p(input logic [24:0] v);
      exp_q.push_back(RUN | v);
   endtask

   // Whole-instruction expected strobe list, one entry per clock cycle
   task automatic build(input logic [4:0] op, input logic c);
      exp_q.delete();
      p(PCOUT | MARIN | INCPC | ZIN); p(ZLOW | PCIN | READ | MDRIN); p(MDROUT | IRIN);
      case (op)
         5'b00000: begin p(GRB | BAOUT | YIN); p(COUT | ZIN); p(ZLOW | MARIN); p(READ | MDRIN); p(MDROUT | GRA | RIN); end
         5'b00001: begin p(GRB | BAOUT | YIN); p(COUT | ZIN); p(ZLOW | GRA | RIN); end
         5'b00010: begin p(GRB | BAOUT | YIN); p(COUT | ZIN); p(ZLOW | MARIN); p(GRA | ROUT | MDRIN); p(WRITE); end
         5'b00011, 5'b00100, 5'b01001, 5'b01010: begin
            p(GRB | ROUT | YIN); p(GRC | ROUT | ZIN | alu_f(op)); p(ZLOW | GRA | RIN);
         end
         5'b01011, 5'b01100, 5'b01101: begin
            p(GRB | ROUT | YIN); p(COUT | ZIN | alu_f(op)); p(ZLOW | GRA | RIN);
         end
         5'b10010: begin p(GRA | ROUT | CONIN); p(PCOUT | YIN); p(COUT | ZIN); p(c ? (ZLOW | PCIN) : 25'd0); end
         5'b10011: p(GRA | ROUT | PCIN);
         5'b11001, 5'b11010: p(25'd0);
         default: p(ILL);
      endcase
   endtask

   // Entered just after a clock edge with the DUT expected in T0.
   task automatic run_instr(input logic [31:0] ir_v, input logic c, input int stop_at, input int upto, input string tag);
      int n;
      logic halting;
      build(ir_v[31:27], c);
      n = exp_q.size();
      if (upto >= 0 && upto < n) n = upto;
      halting = (ir_v[31:27] == 5'b11010) || (stop_at >= 0);
      for (int k = 0; k < n; k++) begin
         if (k == 0) IR = ir_v;
         stop   = (k == stop_at);
         con_ff = (k == 6) ? c : 1'($urandom_range(1));
         @(negedge clock);
         chk($sformatf("%s_t%0d", tag, k), exp_q[k]);
         @(posedge clock); #1;
      end
      stop = 1'b0;
      if (n == exp_q.size()) begin
         if (halting) begin
            @(negedge clock);
            chk($sformatf("%s_halt", tag), 25'd0);
            @(posedge clock); #1;
         end
`ifdef CONTROL_SEQUENCER_STEP_EN
         else begin
            step = 1'b0;
            for (int g = 0; g < 3; g++) begin
               if (g == 2) step = 1'b1;
               @(negedge clock);
               chk($sformatf("%s_pause%0d", tag, g), RUN);
               @(posedge clock); #1;
            end
            step = 1'b0;
         end
`endif
      end
   endtask

   task automatic halt_idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         chk($sformatf("halt_idle%0d", i), 25'd0);
         @(posedge clock); #1;
      end
   endtask

   // pre: 0 expect all zero before first reset edge, 1 expect only run, 2 skip
   task automatic reset_pulse(input int pre);
      reset_n = 1'b0;
      if (pre != 2) begin
         @(negedge clock);
         chk("rst_pre", (pre == 1) ? RUN : 25'd0);
      end
      @(posedge clock); #1;
      @(negedge clock);
      chk("rst_held", RUN);
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   logic [4:0] ops [15] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01001, 5'b01010,
                            5'b01011, 5'b01100, 5'b01101, 5'b10010, 5'b10011, 5'b11001, 5'b00101, 5'b11111};

   initial begin
      reset_n = 1'b0; stop = 1'b0; con_ff = 1'b0; IR = 32'd0;
`ifdef CONTROL_SEQUENCER_STEP_EN
      step = 1'b0;
`endif
      reset_pulse(2);
      run_instr(32'h19918000, 1'b0, -1, -1, "add_r3");
      run_instr({5'b00000, 27'h0123456}, 1'b0, -1, -1, "ld");
      run_instr({5'b10010, 27'h0000040}, 1'b0, -1, -1, "br_c0");
      run_instr({5'b10010, 27'h0000040}, 1'b1, -1, -1, "br_c1");
      run_instr({5'b00010, 27'h0654321}, 1'b0, -1, -1, "st");
      run_instr({5'b00100, 27'h0011111}, 1'b0, -1, -1, "sub");
      run_instr({5'b01101, 27'h0022222}, 1'b0, -1, -1, "ori");
      run_instr({5'b10011, 27'h0000000}, 1'b0, -1, -1, "jr");
      run_instr({5'b11111, 27'h7ffffff}, 1'b0, -1, -1, "illegal");
      for (int i = 0; i < 30; i++) begin
         run_instr({ops[$urandom_range(14)], 27'($urandom)}, 1'($urandom_range(1)), -1, -1, $sformatf("rnd%0d", i));
      end
      run_instr(32'h19918000, 1'b0, -1, 4, "rst_add");
      reset_pulse(1);
      run_instr({5'b01011, 27'h0333333}, 1'b0, 4, -1, "stop_addi");
      halt_idle(3);
      reset_pulse(0);
      run_instr({5'b11001, 27'h0000000}, 1'b0, -1, -1, "nop");
      run_instr({5'b11010, 27'h0000000}, 1'b0, -1, -1, "halt");
      halt_idle(20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
